alarm_controller: RTL and testbench
===================================

Name: alarm_controller

Overview:
- Sits downstream of countinglogic; consumes its BCD HH:MM display_value (as current_time) and the same one_minute tick.
- Holds a programmable alarm time and raises ringing when the running time reaches it.
- Provides snooze, manual off and an automatic ring timeout; drives the buzzer/LED driver and the alarm-time display mux.
- Single synchronous clock domain; one_minute is a 1-cycle strobe already synchronised to clk.

Parameters:
- SNOOZE_MIN, 9, snooze length in minutes; legal 1..59.
- RING_TIMEOUT_MIN, 30, minutes of unattended ringing before auto-silence; legal 1..59.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- one_minute  in  1  1-cycle strobe, once per minute.
- current_time  in  16  BCD HHMM from countinglogic: [15:12] hour tens, [11:8] hour units, [7:4] minute tens, [3:0] minute units.
- alarm_enable  in  1  level; 0 forces IDLE.
- set_alarm  in  1  1-cycle strobe; load new_alarm.
- new_alarm  in  16  BCD HHMM candidate alarm time.
- snooze  in  1  1-cycle strobe.
- alarm_off  in  1  1-cycle strobe.
- alarm_time  out  16  stored alarm, BCD HHMM.
- ringing  out  1  high while in RINGING.
- snoozing  out  1  high while in SNOOZING.
- set_error  out  1  1-cycle pulse when set_alarm carries an invalid time.

Behaviour:
- Reset (async, active-high): state=IDLE, alarm_time=16'h0000, ringing=0, snoozing=0, set_error=0, all counters=0, match_d=0.
- All outputs are registered. Every event is reflected on outputs at the clk edge that samples it (1-cycle latency).
- Validity rule: hour tens ≤2, hour units ≤9, hour ≤23 (tens=2 requires units ≤3), minute tens ≤5, minute units ≤9.
- set_alarm with a valid new_alarm: alarm_time←new_alarm.
  - If the state is RINGING or SNOOZING, go to ARMED.
  - IDLE and ARMED are unchanged.
- set_alarm with an invalid new_alarm: alarm_time is unchanged, set_error=1 for one cycle, and the state is unaffected.
- Match detection:
  - match = (current_time == alarm_time), 16-bit compare.
  - match_d is a register updated every cycle in every state.
  - Trigger = match & ~match_d.
  - Consequences: ringing fires once per match minute; enabling while already in the match minute does not ring; alarm_off within the match minute does not re-ring.
- States:
  - IDLE: alarm_enable=1 → ARMED.
  - ARMED: trigger → RINGING, ring_cnt←0.
  - RINGING:
    - alarm_off → ARMED.
    - Else snooze → SNOOZING, snz_cnt←SNOOZE_MIN.
    - Else on one_minute: ring_cnt+1; if ring_cnt+1 == RING_TIMEOUT_MIN → ARMED.
  - SNOOZING:
    - alarm_off → ARMED.
    - Else on one_minute: snz_cnt−1; on reaching 0 → RINGING, ring_cnt←0.
    - snooze while SNOOZING is ignored (no restart).
- Priority, highest first:
  1. reset
  2. alarm_enable=0 (→IDLE from any state, counters cleared)
  3. valid set_alarm
  4. alarm_off
  5. snooze
  6. one_minute counting
  7. trigger
- Simultaneous cases:
  - set_alarm and trigger in the same cycle: the set wins. match_d still samples, so a new alarm equal to current_time rings on the next cycle if match rises.
  - one_minute and trigger in the same cycle while ARMED: trigger wins; that one_minute is not counted toward ring_cnt.
- Counters are 6 bits. No wrap is possible given the parameter ranges; out-of-range parameters are a compile-time error (static assertion).
- ringing = (state==RINGING); snoozing = (state==SNOOZING), both registered with the state.

Decomposition:
- Shared package alarm_pkg:
  - state enum {IDLE, ARMED, RINGING, SNOOZING}, 2 bits.
  - BCD field index constants (HT, HU, MT, MU).
  - Function bcd_time_valid(16-bit) returning 1 bit, reused by the time-set path of countinglogic.
- One natural sub-module: minute_counter, a 6-bit load/increment/decrement counter with terminal flag, advanced by one_minute. Instantiate it twice, for ring_cnt and snz_cnt.

Test Plan:
- Reset mid-RINGING → next sample: ringing=0, alarm_time=16'h0000, state IDLE; after release with enable=1 → ARMED and no ringing while current_time=0000.
- enable=1, set_alarm new_alarm=16'h0730, current_time steps 0729→0730 → ringing=1 one cycle after 0730 appears; alarm_off → ringing=0; current_time held at 0730 for 100 cycles → ringing stays 0.
- Ringing at 0730, snooze → snoozing=1; 8 one_minute pulses → still snoozing; 9th pulse → ringing=1, snoozing=0.
- Ringing with RING_TIMEOUT_MIN=30 and no input → ringing drops exactly on the 30th one_minute pulse, state ARMED; at next day's 0730 ringing=1 again.
- set_alarm new_alarm=16'h2460, then 16'h1A00 → set_error pulses 1 cycle each, alarm_time unchanged; 16'h2359 → accepted, set_error=0.
- alarm_enable=0 and snooze in the same cycle while RINGING → IDLE, ringing=0, snoozing=0; re-enable during the same match minute → no ring.

Source files
------------

// File: rtl/alarm_pkg.sv
// Shared types and helpers for the alarm controller and the clock's time-set path.
// Holds the controller state encoding, BCD field positions and the BCD HH:MM validity check.
package alarm_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ARMED    = 2'd1,
        RINGING  = 2'd2,
        SNOOZING = 2'd3
    } alarm_state_t;

    // Nibble positions inside a BCD HHMM word
    localparam int HT = 3;
    localparam int HU = 2;
    localparam int MT = 1;
    localparam int MU = 0;

    localparam int CNT_W = 6;

    function automatic logic bcd_time_valid(input logic [15:0] t);
        logic [3:0] ht;
        logic [3:0] hu;
        logic [3:0] mt;
        logic [3:0] mu;
        ht = t[HT*4 +: 4];
        hu = t[HU*4 +: 4];
        mt = t[MT*4 +: 4];
        mu = t[MU*4 +: 4];
        return (ht <= 4'd2) && (hu <= 4'd9) && !((ht == 4'd2) && (hu > 4'd3)) &&
               (mt <= 4'd5) && (mu <= 4'd9);
    endfunction

endpackage

// File: rtl/alarm_controller_minute_counter.sv
// Six-bit minute counter with synchronous clear/load/increment/decrement.
// The terminal flag compares the current count against a caller-supplied value.
module minute_counter
    import alarm_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             inc,
    input  logic             dec,
    input  logic [CNT_W-1:0] term,
    output logic             terminal
);

    logic [CNT_W-1:0] count_r;

    // Count register; clear dominates load, load dominates stepping
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_r <= 6'd0;
        end else if (clear) begin
            count_r <= 6'd0;
        end else if (load) begin
            count_r <= load_val;
        end else if (inc) begin
            count_r <= count_r + 6'd1;
        end else if (dec) begin
            count_r <= count_r - 6'd1;
        end
    end

    assign terminal = (count_r == term);

endmodule

// File: rtl/alarm_controller.sv
// Alarm controller: stores the alarm time, rings on the rising edge of a time match,
// and handles snooze, manual off and an automatic ring timeout.
module alarm_controller
    import alarm_pkg::*;
#(
    parameter int SNOOZE_MIN       = 9,
    parameter int RING_TIMEOUT_MIN = 30
)
(
    input  logic        clk,
    input  logic        reset,
    input  logic        one_minute,
    input  logic [15:0] current_time,
    input  logic        alarm_enable,
    input  logic        set_alarm,
    input  logic [15:0] new_alarm,
    input  logic        snooze,
    input  logic        alarm_off,
    output logic [15:0] alarm_time,
    output logic        ringing,
    output logic        snoozing,
    output logic        set_error
);

    if ((SNOOZE_MIN < 1) || (SNOOZE_MIN > 59)) begin : g_bad_snooze
        $error("SNOOZE_MIN must be within 1..59");
    end
    if ((RING_TIMEOUT_MIN < 1) || (RING_TIMEOUT_MIN > 59)) begin : g_bad_timeout
        $error("RING_TIMEOUT_MIN must be within 1..59");
    end

    localparam logic [CNT_W-1:0] SNOOZE_LOAD = CNT_W'(SNOOZE_MIN);
    // The ring counter is checked before it increments, hence the minus one
    localparam logic [CNT_W-1:0] RING_TERM   = CNT_W'(RING_TIMEOUT_MIN - 1);

    alarm_state_t state_r;
    alarm_state_t state_n_s;
    logic [15:0]  alarm_time_r;
    logic         ringing_r;
    logic         snoozing_r;
    logic         set_error_r;
    logic         match_d_r;
    logic         match_s;
    logic         trigger_s;
    logic         set_ok_s;
    logic         set_valid_s;
    logic         ring_clr_s;
    logic         ring_ld_s;
    logic         ring_inc_s;
    logic         ring_term_s;
    logic         snz_clr_s;
    logic         snz_ld_s;
    logic         snz_dec_s;
    logic         snz_term_s;

    assign match_s     = (current_time == alarm_time_r);
    assign trigger_s   = match_s & ~match_d_r;
    assign set_ok_s    = bcd_time_valid(new_alarm);
    assign set_valid_s = set_alarm & set_ok_s;

    minute_counter u_ring_cnt (
        .clk      (clk),
        .reset    (reset),
        .clear    (ring_clr_s),
        .load     (ring_ld_s),
        .load_val (6'd0),
        .inc      (ring_inc_s),
        .dec      (1'b0),
        .term     (RING_TERM),
        .terminal (ring_term_s)
    );

    minute_counter u_snz_cnt (
        .clk      (clk),
        .reset    (reset),
        .clear    (snz_clr_s),
        .load     (snz_ld_s),
        .load_val (SNOOZE_LOAD),
        .inc      (1'b0),
        .dec      (snz_dec_s),
        .term     (6'd1),
        .terminal (snz_term_s)
    );

    // Next-state and counter control, in event priority order
    always_comb begin
        state_n_s  = state_r;
        ring_clr_s = 1'b0;
        ring_ld_s  = 1'b0;
        ring_inc_s = 1'b0;
        snz_clr_s  = 1'b0;
        snz_ld_s   = 1'b0;
        snz_dec_s  = 1'b0;
        if (!alarm_enable) begin
            state_n_s  = IDLE;
            ring_clr_s = 1'b1;
            snz_clr_s  = 1'b1;
        end else if (set_valid_s) begin
            // A new alarm silences any ringing/snooze; IDLE arms because enable is high
            state_n_s = ARMED;
        end else begin
            case (state_r)
                IDLE: begin
                    state_n_s = ARMED;
                end
                ARMED: begin
                    if (trigger_s) begin
                        state_n_s = RINGING;
                        ring_ld_s = 1'b1;
                    end else begin
                        state_n_s = ARMED;
                    end
                end
                RINGING: begin
                    if (alarm_off) begin
                        state_n_s = ARMED;
                    end else if (snooze) begin
                        state_n_s = SNOOZING;
                        snz_ld_s  = 1'b1;
                    end else if (one_minute) begin
                        ring_inc_s = 1'b1;
                        state_n_s  = ring_term_s ? ARMED : RINGING;
                    end else begin
                        state_n_s = RINGING;
                    end
                end
                SNOOZING: begin
                    if (alarm_off) begin
                        state_n_s = ARMED;
                    end else if (one_minute) begin
                        snz_dec_s = 1'b1;
                        if (snz_term_s) begin
                            state_n_s = RINGING;
                            ring_ld_s = 1'b1;
                        end else begin
                            state_n_s = SNOOZING;
                        end
                    end else begin
                        state_n_s = SNOOZING;
                    end
                end
                default: begin
                    state_n_s = IDLE;
                end
            endcase
        end
    end

    // State, stored alarm, match history and registered outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r      <= IDLE;
            alarm_time_r <= 16'h0000;
            ringing_r    <= 1'b0;
            snoozing_r   <= 1'b0;
            set_error_r  <= 1'b0;
            match_d_r    <= 1'b0;
        end else begin
            state_r     <= state_n_s;
            ringing_r   <= (state_n_s == RINGING);
            snoozing_r  <= (state_n_s == SNOOZING);
            set_error_r <= set_alarm & ~set_ok_s;
            match_d_r   <= match_s;
            if (set_valid_s) begin
                alarm_time_r <= new_alarm;
            end
        end
    end

    assign alarm_time = alarm_time_r;
    assign ringing    = ringing_r;
    assign snoozing   = snoozing_r;
    assign set_error  = set_error_r;

endmodule

// File: tb/tb_alarm_controller.sv
// Scoreboard bench for alarm_controller: directed scenarios followed by randomized traffic,
// checked every cycle against a behavioural alarm-clock model.
module tb_alarm_controller;

    localparam int SNZ_MIN = 9;
    localparam int TMO_MIN = 30;
    localparam int M_IDLE = 0, M_ARMED = 1, M_RING = 2, M_SNZ = 3;

    logic        clk = 1'b0;
    logic        reset, one_minute, alarm_enable, set_alarm, snooze, alarm_off;
    logic [15:0] current_time, new_alarm;
    logic [15:0] alarm_time;
    logic        ringing, snoozing, set_error;

    logic [18:0] exp_q[$];
    int          n_cmp = 0;
    int          n_bad = 0;

    // Reference model state
    logic [15:0] m_alarm;
    int          m_mode, m_rung, m_left;
    bit          m_seen_match, m_err;

    alarm_controller #(.SNOOZE_MIN(SNZ_MIN), .RING_TIMEOUT_MIN(TMO_MIN)) dut (
        .clk(clk), .reset(reset), .one_minute(one_minute), .current_time(current_time),
        .alarm_enable(alarm_enable), .set_alarm(set_alarm), .new_alarm(new_alarm),
        .snooze(snooze), .alarm_off(alarm_off), .alarm_time(alarm_time),
        .ringing(ringing), .snoozing(snoozing), .set_error(set_error)
    );

    always #5 clk = ~clk;

    function automatic bit time_ok(input logic [15:0] t);
        int h, m;
        if (t[15:12] > 4'd9 || t[11:8] > 4'd9 || t[7:4] > 4'd9 || t[3:0] > 4'd9) return 1'b0;
        h = int'(t[15:12]) * 10 + int'(t[11:8]);
        m = int'(t[7:4]) * 10 + int'(t[3:0]);
        return (h < 24) && (m < 60);
    endfunction

    task automatic model_step();
        bit match_now, rises, good_set;
        if (reset) begin
            m_alarm = 16'h0000; m_mode = M_IDLE; m_rung = 0; m_left = 0;
            m_seen_match = 1'b0; m_err = 1'b0;
        end else begin
            match_now    = (current_time == m_alarm);
            rises        = match_now && !m_seen_match;
            m_seen_match = match_now;
            good_set     = set_alarm && time_ok(new_alarm);
            m_err        = set_alarm && !time_ok(new_alarm);
            if (!alarm_enable) begin
                m_mode = M_IDLE; m_rung = 0; m_left = 0;
            end else if (good_set) begin
                m_mode = M_ARMED;
            end else if (m_mode == M_IDLE) begin
                m_mode = M_ARMED;
            end else if (m_mode == M_ARMED) begin
                if (rises) begin m_mode = M_RING; m_rung = 0; end
            end else if (m_mode == M_RING) begin
                if (alarm_off) m_mode = M_ARMED;
                else if (snooze) begin m_mode = M_SNZ; m_left = SNZ_MIN; end
                else if (one_minute) begin
                    m_rung++;
                    if (m_rung == TMO_MIN) m_mode = M_ARMED;
                end
            end else begin
                if (alarm_off) m_mode = M_ARMED;
                else if (one_minute) begin
                    m_left--;
                    if (m_left == 0) begin m_mode = M_RING; m_rung = 0; end
                end
            end
            if (good_set) m_alarm = new_alarm;
        end
    endtask

    // Apply the current input values for one clock, record the expected response
    task automatic cyc();
        logic [18:0] e;
        model_step();
        e = {m_alarm, (m_mode == M_RING), (m_mode == M_SNZ), m_err};
        exp_q.push_back(e);
        @(negedge clk);
        reset = 1'b0; set_alarm = 1'b0; snooze = 1'b0; alarm_off = 1'b0; one_minute = 1'b0;
    endtask

    task automatic cycles(input int n);
        for (int k = 0; k < n; k++) cyc();
    endtask

    task automatic minute_pulses(input int n);
        for (int k = 0; k < n; k++) begin
            one_minute = 1'b1; cyc(); cyc();
        end
    endtask

    task automatic set_to(input logic [15:0] t);
        set_alarm = 1'b1; new_alarm = t; cyc();
    endtask

    // Monitor: one registered response per clock, compared just after the edge
    initial begin
        logic [18:0] e, g;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                g = {alarm_time, ringing, snoozing, set_error};
                n_cmp++;
                if (g !== e) begin
                    n_bad++;
                    $display("FAIL outputs @%0t: got alarm_time=%h ringing=%b snoozing=%b set_error=%b, want alarm_time=%h ringing=%b snoozing=%b set_error=%b",
                             $time, g[18:3], g[2], g[1], g[0], e[18:3], e[2], e[1], e[0]);
                end
            end
        end
    end

    initial begin
        logic [15:0] pool[5];
        pool[0] = 16'h0730; pool[1] = 16'h1200; pool[2] = 16'h2359;
        pool[3] = 16'h0000; pool[4] = 16'h0731;
        reset = 1'b1; one_minute = 1'b0; alarm_enable = 1'b0; set_alarm = 1'b0;
        snooze = 1'b0; alarm_off = 1'b0; current_time = 16'h0000; new_alarm = 16'h0000;
        @(negedge clk);
        reset = 1'b1; cyc();
        alarm_enable = 1'b1; cycles(3);

        // Basic ring at 07:30 and manual off holding through the match minute
        set_to(16'h0730);
        current_time = 16'h0729; cycles(2);
        current_time = 16'h0730; cycles(3);
        alarm_off = 1'b1; cyc();
        cycles(100);

        // Snooze expires on the ninth minute
        current_time = 16'h0731; cyc();
        current_time = 16'h0730; cycles(2);
        snooze = 1'b1; cyc();
        snooze = 1'b1; cyc();
        minute_pulses(8);
        cycles(2);
        minute_pulses(1);
        cycles(2);

        // Unattended ring times out on the 30th minute, rings again next day
        alarm_off = 1'b1; cyc();
        current_time = 16'h0000; cyc();
        current_time = 16'h0730; cyc();
        minute_pulses(29);
        minute_pulses(1);
        current_time = 16'h0000; cycles(3);
        current_time = 16'h0730; cycles(3);

        // Reset while ringing, then re-arm with current_time equal to the reset alarm
        reset = 1'b1; cyc();
        current_time = 16'h0000; cycles(5);

        // Invalid alarm times are rejected, a valid one is accepted
        set_to(16'h2460); cyc();
        set_to(16'h1A00); cyc();
        set_to(16'h2359); cyc();

        // Disable with a simultaneous snooze, then re-enable inside the match minute
        set_to(16'h0730);
        current_time = 16'h0729; cyc();
        current_time = 16'h0730; cycles(2);
        alarm_enable = 1'b0; snooze = 1'b1; cyc();
        alarm_enable = 1'b1; cycles(5);

        // Set beats trigger; a set equal to the running time rings next cycle
        current_time = 16'h0729; cycles(2);
        current_time = 16'h0730; set_alarm = 1'b1; new_alarm = 16'h0900; cyc();
        cycles(2);
        current_time = 16'h1000; set_alarm = 1'b1; new_alarm = 16'h1000; cyc();
        cycles(2);

        // one_minute coincident with trigger is not counted
        alarm_off = 1'b1; cyc();
        current_time = 16'h1001; cyc();
        current_time = 16'h1000; one_minute = 1'b1; cyc();
        minute_pulses(31);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            alarm_enable = ($urandom_range(0, 149) != 0);
            reset        = ($urandom_range(0, 999) == 0);
            one_minute   = ($urandom_range(0, 3) == 0);
            snooze       = ($urandom_range(0, 19) == 0);
            alarm_off    = ($urandom_range(0, 39) == 0);
            set_alarm    = ($urandom_range(0, 49) == 0);
            new_alarm    = ($urandom_range(0, 1) == 0) ? pool[$urandom_range(0, 4)] : 16'($urandom);
            if ($urandom_range(0, 7) == 0)
                current_time = ($urandom_range(0, 1) == 0) ? m_alarm : pool[$urandom_range(0, 4)];
            cyc();
        end

        for (int k = 0; k < 10 && exp_q.size() > 0; k++) @(negedge clk);
        if (exp_q.size() > 0) begin
            n_bad++;
            $display("FAIL drain: %0d responses still pending, want 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
